sr_fetch_queue: RTL

SR_FETCH_QUEUE -- requirements
Module: sr_fetch_queue

---
 rtl/sr_fetch_queue_pkg.sv | 17 +
 rtl/sr_fetch_queue_fifo.sv | 50 +++++
 rtl/sr_fetch_queue.sv | 79 +++++++
 3 files changed

// File: rtl/sr_fetch_queue_pkg.sv
// Shared fetch-stage definitions: instruction encodings, PC stepping and the queue entry layout.
package sr_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/sr_fetch_queue_fifo.sv
// Circular instruction queue of {pc, instr} entries with push/pop/flush and an occupancy count.
module sr_fetch_fifo
  import sr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 pushData,
  input  logic                         pop,
  output fetch_entry_t                 headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;

  // DEPTH is a power of two, so pointers wrap without an explicit compare.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + PTR_ONE;
      if (pop)  headPtr <= headPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[tailPtr] <= pushData;
  end

  assign headData = mem[headPtr];

endmodule

// File: rtl/sr_fetch_queue.sv
// Fetch stage: issues sequential imem reads under a credit check and buffers responses in order.
module sr_fetch_queue
  import sr_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DW    = CNT_W + 1;

  logic [31:0]      fpc;
  logic [31:0]      issuedPc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    demand;
  logic             doIssue;
  logic             doPush;
  logic             doPop;
  fetch_entry_t     headEntry;
  fetch_entry_t     pushEntry;

  // Head handshake: valid_o is the valid, !freeze is the ready; the head
  // leaves on valid_o && !freeze, and redirect overrides both by flushing.
  assign valid_o = (count != '0);
  assign doPop   = valid_o && !freeze && !redirect;
  assign doPush  = inflight && !redirect;

  // Slots already committed (queued plus the response on its way) after this cycle's pop.
  assign demand  = {1'b0, count} + DW'(inflight) - DW'(doPop);
  assign doIssue = !redirect && (demand < DW'(DEPTH));

  assign imem_addr = fpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_PC;
      issuedPc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= doIssue;
      if (doIssue) begin
        fpc      <= nextPc(fpc);
        issuedPc <= fpc;
      end
    end
  end

  assign pushEntry = '{pc: issuedPc, instr: imem_rdata};

  sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (doPush),
    .pushData (pushEntry),
    .pop      (doPop),
    .headData (headEntry),
    .count    (count)
  );

  assign pc_o    = valid_o ? headEntry.pc    : fpc;
  assign instr_o = valid_o ? headEntry.instr : NOP_INSTR;

endmodule
